// File: rtl/lbp_hist.sv
// lbp_hist: histogram of LBP codes over interior pixels, streamed out over valid/ready after finish.
// Optional macro LBP_HIST_UNIFORM_EN folds codes into 58 uniform bins plus one catch-all bin.
module lbp_hist #(
  parameter int CNT_W    = 14,
  parameter int IMG_LOG2 = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*IMG_LOG2-1:0] lbp_addr,
  input  logic                  lbp_valid,
  input  logic [7:0]            lbp_data,
  input  logic                  finish,
  output logic [7:0]            hist_addr,
  output logic [CNT_W-1:0]      hist_data,
  output logic                  hist_valid,
  input  logic                  hist_ready,
  output logic                  hist_done,
  output logic                  hist_sat
);

`ifdef LBP_HIST_UNIFORM_EN
  localparam logic [7:0] LAST_BIN = 8'd58;
`else
  localparam logic [7:0] LAST_BIN = 8'd255;
`endif
  localparam logic [IMG_LOG2-1:0] EDGE_MAX = IMG_LOG2'((2 ** IMG_LOG2) - 2);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

`ifdef LBP_HIST_UNIFORM_EN
  function automatic logic is_uniform(input logic [7:0] code);
    logic [7:0] diff;
    logic [3:0] n;
    diff = code ^ {code[0], code[7:1]};
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, diff[i]};
    return (n <= 4'd2);
  endfunction
`endif

  // Uniform mode: bin = rank of the code among uniform codes; everything else shares the last bin.
  function automatic logic [7:0] map_bin(input logic [7:0] code);
`ifdef LBP_HIST_UNIFORM_EN
    logic [7:0] idx;
    idx = 8'd0;
    for (int i = 0; i < 256; i++) begin
      if ((i < int'(code)) && is_uniform(8'(i))) idx = idx + 8'd1;
    end
    return is_uniform(code) ? idx : LAST_BIN;
`else
    return code;
`endif
  endfunction

  state_t              state_r, state_s;
  logic [7:0]          s1_bin_r, s2_bin_r;
  logic                s1_acc_r, s2_acc_r, flush_cnt_r;
  logic [CNT_W-1:0]    s2_base_r;
  logic [255:0]        touched_r;
  logic [CNT_W-1:0]    mem_r [256];

  logic                accept_s, drain_start_s, beat_s, interior_s, s2_full_s, fwd_s;
  logic [CNT_W-1:0]    s2_wval_s, rd_val_s;
  logic [7:0]          rd_addr_s;
  logic [IMG_LOG2-1:0] row_s, col_s;

  assign row_s      = lbp_addr[2*IMG_LOG2-1 -: IMG_LOG2];
  assign col_s      = lbp_addr[IMG_LOG2-1:0];
  assign interior_s = (row_s != {IMG_LOG2{1'b0}}) && (row_s <= EDGE_MAX) &&
                      (col_s != {IMG_LOG2{1'b0}}) && (col_s <= EDGE_MAX);

  assign s2_full_s = (s2_base_r == {CNT_W{1'b1}});
  assign s2_wval_s = s2_full_s ? s2_base_r : (s2_base_r + {{(CNT_W-1){1'b0}}, 1'b1});

  // Single read port: pipeline lookup while accumulating, next drain bin otherwise.
  always_comb begin
    rd_addr_s = 8'd0;
    if (s1_acc_r) begin
      rd_addr_s = s1_bin_r;
    end else if (state_r == DRAIN) begin
      rd_addr_s = hist_addr + 8'd1;
    end else begin
      rd_addr_s = 8'd0;
    end
  end

  // The S2 write lands on the same edge as this read, so bypass it when addresses match.
  assign fwd_s    = s2_acc_r && (s2_bin_r == rd_addr_s);
  assign rd_val_s = fwd_s ? s2_wval_s :
                    (touched_r[rd_addr_s] ? mem_r[rd_addr_s] : {CNT_W{1'b0}});

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_s       = state_r;
    accept_s      = 1'b0;
    drain_start_s = 1'b0;
    beat_s        = 1'b0;
    case (state_r)
      ACCUM: begin
        accept_s = lbp_valid && interior_s;
        if (finish) state_s = FLUSH;
        else        state_s = ACCUM;
      end
      FLUSH: begin
        if (flush_cnt_r) begin
          state_s       = DRAIN;
          drain_start_s = 1'b1;
        end else begin
          state_s = FLUSH;
        end
      end
      DRAIN: begin
        beat_s = hist_valid && hist_ready;
        if (beat_s && (hist_addr == LAST_BIN)) state_s = DONE;
        else                                   state_s = DRAIN;
      end
      DONE:    state_s = DONE;
      default: state_s = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ACCUM;
    else       state_r <= state_s;
  end

  // Accumulate pipeline, touched flags, and the registered drain outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_bin_r    <= 8'd0;
      s1_acc_r    <= 1'b0;
      s2_bin_r    <= 8'd0;
      s2_acc_r    <= 1'b0;
      s2_base_r   <= {CNT_W{1'b0}};
      flush_cnt_r <= 1'b0;
      touched_r   <= 256'd0;
      hist_addr   <= 8'd0;
      hist_data   <= {CNT_W{1'b0}};
      hist_valid  <= 1'b0;
      hist_done   <= 1'b0;
      hist_sat    <= 1'b0;
    end else begin
      s1_bin_r    <= map_bin(lbp_data);
      s1_acc_r    <= accept_s;
      s2_bin_r    <= s1_bin_r;
      s2_acc_r    <= s1_acc_r;
      s2_base_r   <= rd_val_s;
      flush_cnt_r <= (state_r == FLUSH) ? ~flush_cnt_r : 1'b0;
      if (s2_acc_r) begin
        touched_r[s2_bin_r] <= 1'b1;
        if (s2_full_s) hist_sat <= 1'b1;
      end
      if (drain_start_s) begin
        hist_valid <= 1'b1;
        hist_addr  <= 8'd0;
        hist_data  <= rd_val_s;
      end else if (beat_s) begin
        if (hist_addr == LAST_BIN) begin
          hist_valid <= 1'b0;
          hist_done  <= 1'b1;
        end else begin
          hist_addr <= hist_addr + 8'd1;
          hist_data <= rd_val_s;
        end
      end
    end
  end

  // Bin array write port; no reset so it stays RAM-mappable.
  always_ff @(posedge clk) begin
    if (s2_acc_r) mem_r[s2_bin_r] <= s2_wval_s;
  end

endmodule
